// File: rtl/mag_cmp_pipe.sv
// Pipelined magnitude comparator: one SLICE-bit slice per stage, MS slice first,
// optional two's-complement mode, cascade inputs resolve ties, valid/ready flow.
module mag_cmp_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             cin_lt,
    input  logic             cin_eq,
    input  logic             cin_gt,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned SL   = (SLICE < 1) ? 1 : SLICE;
    localparam int unsigned NST  = WIDTH / SL;
    localparam int unsigned LAST = NST - 1;

    // Reject slice geometries that cannot tile the operand
    generate
        if (SLICE < 1 || WIDTH == 0 || (WIDTH % SL) != 0) begin : g_param_check
            $fatal(1, "mag_cmp_pipe: WIDTH must be a non-zero multiple of SLICE (SLICE >= 1)");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EQ = 2'b00,
        ST_LT = 2'b01,
        ST_GT = 2'b10
    } cmp_st_e;

    // Compare one slice unless an earlier (more significant) slice already decided
    function automatic cmp_st_e cmp_slice(input cmp_st_e st, input logic [SL-1:0] sa,
                                          input logic [SL-1:0] sb, input logic sgn);
        cmp_st_e res;
        res = st;
        if (st == ST_EQ) begin
            if (sgn) begin
                if ($signed(sa) < $signed(sb))      res = ST_LT;
                else if ($signed(sa) > $signed(sb)) res = ST_GT;
            end else begin
                if (sa < sb)      res = ST_LT;
                else if (sa > sb) res = ST_GT;
            end
        end
        return res;
    endfunction

    // Map running state plus cascade bits {lt,eq,gt} to one-hot {lt,eq,gt}
    function automatic logic [2:0] resolve(input cmp_st_e st, input logic [2:0] cin);
        logic [2:0] res;
        case (st)
            ST_LT:   res = 3'b100;
            ST_GT:   res = 3'b001;
            default: begin
                if (cin[1])      res = 3'b010;
                else if (cin[0]) res = 3'b001;
                else if (cin[2]) res = 3'b100;
                else             res = 3'b010;
            end
        endcase
        return res;
    endfunction

    // Values entering slice k: index 0 is the input port, index k>0 is stage register k-1
    logic             w_vld    [NST];
    logic [2:0]       w_cin    [NST];
    logic [TAG_W-1:0] w_tag    [NST];
    cmp_st_e          w_st_in  [NST];
    cmp_st_e          w_st_res [NST];
    logic [SL-1:0]    w_sa     [NST];
    logic [SL-1:0]    w_sb     [NST];
    logic             w_adv;
    logic [2:0]       w_res;

    logic             r_out_valid;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [TAG_W-1:0] r_out_tag;

    // Whole pipe moves together; it only stalls when a held result is refused
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    assign w_vld[0]   = in_valid;
    assign w_cin[0]   = {cin_lt, cin_eq, cin_gt};
    assign w_tag[0]   = tag;
    assign w_st_in[0] = ST_EQ;
    assign w_sa[0]    = a[WIDTH-1 -: SL];
    assign w_sb[0]    = b[WIDTH-1 -: SL];

    // Per-slice compare; only the MS slice honours signed mode, so the sign
    // flag never needs to travel past the input
    generate
        for (genvar k = 0; k < NST; k++) begin : g_cmp
            if (k == 0) begin : g_ms
                assign w_st_res[k] = cmp_slice(w_st_in[k], w_sa[k], w_sb[k], signed_mode);
            end else begin : g_ls
                assign w_st_res[k] = cmp_slice(w_st_in[k], w_sa[k], w_sb[k], 1'b0);
            end
        end
    endgenerate

    // Stage registers; each keeps only the operand slices not yet compared
    generate
        for (genvar k = 0; k < LAST; k++) begin : g_stg
            localparam int unsigned REM = WIDTH - SL * (k + 1);

            logic             r_vld;
            logic [2:0]       r_cin;
            logic [TAG_W-1:0] r_tag;
            cmp_st_e          r_st;
            logic [REM-1:0]   r_a;
            logic [REM-1:0]   r_b;
            logic [REM-1:0]   w_a_nx;
            logic [REM-1:0]   w_b_nx;

            if (k == 0) begin : g_src_in
                assign w_a_nx = a[REM-1:0];
                assign w_b_nx = b[REM-1:0];
            end else begin : g_src_prev
                assign w_a_nx = g_stg[k-1].r_a[REM-1:0];
                assign w_b_nx = g_stg[k-1].r_b[REM-1:0];
            end

            // Valid bit: cleared by reset so in-flight work is discarded
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                end else if (w_adv) begin
                    r_vld <= w_vld[k];
                end
            end

            // Payload: shifts with the pipe, meaningless while r_vld is low
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_cin <= w_cin[k];
                    r_tag <= w_tag[k];
                    r_st  <= w_st_res[k];
                    r_a   <= w_a_nx;
                    r_b   <= w_b_nx;
                end
            end

            assign w_vld[k+1]   = r_vld;
            assign w_cin[k+1]   = r_cin;
            assign w_tag[k+1]   = r_tag;
            assign w_st_in[k+1] = r_st;
            assign w_sa[k+1]    = r_a[REM-1 -: SL];
            assign w_sb[k+1]    = r_b[REM-1 -: SL];
        end
    endgenerate

    assign w_res = resolve(w_st_res[LAST], w_cin[LAST]);

    // Output register: last slice compare plus cascade resolution, held under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_vld[LAST];
            r_lt        <= w_vld[LAST] & w_res[2];
            r_eq        <= w_vld[LAST] & w_res[1];
            r_gt        <= w_vld[LAST] & w_res[0];
            r_out_tag   <= w_vld[LAST] ? w_tag[LAST] : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// Bench for mag_cmp_pipe: whole-word reference compare in an NST-slot pipe model,
// checked every cycle, plus directed vectors with literal expectations.
module tb_mag_cmp_pipe;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NST   = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             cin_lt;
    logic             cin_eq;
    logic             cin_gt;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    mag_cmp_pipe #(.WIDTH(WIDTH), .SLICE(SLICE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .cin_lt(cin_lt), .cin_eq(cin_eq), .cin_gt(cin_gt),
        .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .lt(lt), .eq(eq), .gt(gt), .out_tag(out_tag)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    logic [TAG_W-1:0] pops [$];
    int               pop_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer compare of the whole words, then cascade tie-break
    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic sgn, input logic cl, input logic ce,
                                           input logic cg);
        int xi;
        int yi;
        if (sgn) begin
            xi = int'($signed(x));
            yi = int'($signed(y));
        end else begin
            xi = int'({16'h0, x});
            yi = int'({16'h0, y});
        end
        if (xi < yi) return 3'b100;
        if (xi > yi) return 3'b001;
        if (ce)      return 3'b010;
        if (cg)      return 3'b001;
        if (cl)      return 3'b100;
        return 3'b010;
    endfunction

    // Pipe model: NST slots, last one is the output; all slots move when output is free or taken
    logic             m_v   [NST];
    logic [2:0]       m_res [NST];
    logic [TAG_W-1:0] m_tag [NST];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < NST; i++) m_v[i] = 1'b0;
        end else if (!m_v[NST-1] || out_ready) begin
            for (int i = NST - 1; i > 0; i--) begin
                m_v[i]   = m_v[i-1];
                m_res[i] = m_res[i-1];
                m_tag[i] = m_tag[i-1];
            end
            m_v[0]   = in_valid;
            m_res[0] = ref_cmp(a, b, signed_mode, cin_lt, cin_eq, cin_gt);
            m_tag[0] = tag;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_v[NST-1]));
            chk("in_ready", 32'(in_ready), 32'(!m_v[NST-1] || out_ready));
            if (m_v[NST-1]) begin
                chk("result", 32'({lt, eq, gt}), 32'(m_res[NST-1]));
                chk("out_tag", 32'(out_tag), 32'(m_tag[NST-1]));
            end else begin
                chk("idle_result", 32'({lt, eq, gt}), 32'(3'b000));
            end
            if (out_valid && out_ready) begin
                pops.push_back(out_tag);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_in(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic sgn, input logic cl, input logic ce, input logic cg,
                          input logic [TAG_W-1:0] tg);
        a = xa; b = xb; signed_mode = sgn;
        cin_lt = cl; cin_eq = ce; cin_gt = cg; tag = tg;
    endtask

    // One compare on an empty pipe with out_ready high; checks exact latency and literal result
    task automatic drive_one(input string name, input logic [WIDTH-1:0] xa,
                             input logic [WIDTH-1:0] xb, input logic sgn, input logic cl,
                             input logic ce, input logic cg, input logic [TAG_W-1:0] tg,
                             input logic [2:0] exp_res);
        @(posedge clk); #1;
        set_in(xa, xb, sgn, cl, ce, cg, tg);
        in_valid = 1'b1;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NST - 2) @(posedge clk);
        @(negedge clk);
        chk({name, " early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " ltEqGt"}, 32'({lt, eq, gt}), 32'(exp_res));
        chk({name, " tag"}, 32'(out_tag), 32'(tg));
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset ltEqGt", 32'({lt, eq, gt}), 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);

        // Directed vectors, expectations worked out by hand
        drive_one("t1_unsigned_lt", 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 3'b100);
        drive_one("t2_cin_gt",      16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 3'b001);
        drive_one("t2_cin_eq_gt",   16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 3'b010);
        drive_one("t2_cin_none",    16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 3'b010);
        drive_one("t2_cin_lt",      16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 3'b100);
        drive_one("t2_cin_ignored", 16'hBEF0, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 3'b001);
        drive_one("t3_signed_lt",   16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 3'b100);
        drive_one("t3_unsigned_gt", 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 3'b001);
        drive_one("t3_signed_gt",   16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 3'b001);
        drive_one("t3_signed_lsb",  16'h7FF0, 16'h7FF8, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 3'b100);

        // Streaming: 8 back-to-back compares
        repeat (2) @(posedge clk);
        pops.delete(); pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set_in(16'(i * 16'h1111), 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i));
            in_valid = 1'b1;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (NST + 2) @(posedge clk);
        chk("stream count", 32'(pops.size()), 32'd8);
        if (pops.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream tag order", 32'(pops[i]), 32'(i));
                chk("stream consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
            end
        end

        // Back-pressure: stall 5 cycles while results are pending
        pops.delete(); pop_cyc.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    set_in(16'h0100 * 16'(i), 16'h0300, 1'b0, 1'b0, 1'b0, 1'b1, 4'(8 + i));
                    in_valid = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!in_ready && w < 50);
                    if (w >= 50) chk("bp producer timeout", 32'(in_ready), 32'd1);
                end
                @(posedge clk); #1 in_valid = 1'b0;
            end
            begin
                int ws;
                ws = 0;
                do begin
                    @(negedge clk);
                    ws++;
                end while (!out_valid && ws < 50);
                chk("bp first valid", 32'(out_valid), 32'd1);
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp in_ready low", 32'(in_ready), 32'd0);
                    chk("bp held valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (NST + 8) @(posedge clk);
        chk("bp count", 32'(pops.size()), 32'd6);
        if (pops.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("bp tag order", 32'(pops[i]), 32'(8 + i));
        end

        // Reset mid-flight: three in flight, then a one-cycle reset with input still offered
        pops.delete(); pop_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_in(16'h1000, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 4'(1 + i));
            in_valid = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < NST + 3; i++) begin
            @(negedge clk);
            chk("rst no stale valid", 32'(out_valid), 32'd0);
        end
        chk("rst no pops", 32'(pops.size()), 32'd0);
        drive_one("t6_after_reset", 16'h00FF, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 3'b001);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
